seq_divider_4bit: RTL and testbench

//   Multi-cycle restoring divider: unsigned dividend / divisor -> quotient, remainder.
//   One trial subtraction per clock, reusing the team's add/sub datapath style.

---
 rtl/seq_divider_4bit.sv | 176 +++++++++++++++++
 tb/tb_seq_divider_4bit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_4bit.sv
// Multi-cycle restoring divider with start/busy/done handshake, one trial subtraction per clock.
// Define DIV_SIGNED_EN to treat operands as two's complement (results truncate toward zero).
module seq_divider_4bit #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   // ZDIV is a one-cycle resolve step for divide-by-zero; busy stays low through it
   typedef enum logic [1:0] {IDLE, CALC, ZDIV, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] v_q, v_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] p_shift, d_shift, iter_p, iter_d;
   logic [WIDTH:0]   trial;

`ifdef DIV_SIGNED_EN
   logic quo_neg_q, quo_neg_d;
   logic rem_neg_q, rem_neg_d;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? -x : x;
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x, input logic neg);
      return neg ? -x : x;
   endfunction
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      p_d         = p_q;
      d_d         = d_q;
      v_d         = v_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
      quo_neg_d   = quo_neg_q;
      rem_neg_d   = rem_neg_q;
`endif

      // Borrow out of the widened trial subtraction decides the quotient bit
      p_shift = {p_q[WIDTH-2:0], d_q[WIDTH-1]};
      d_shift = {d_q[WIDTH-2:0], 1'b0};
      trial   = {1'b0, p_shift} - {1'b0, v_q};
      if (trial[WIDTH]) begin
         iter_p = p_shift;
         iter_d = d_shift;
      end else begin
         iter_p = trial[WIDTH-1:0];
         iter_d = d_shift | WIDTH'(1);
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               dbz_d = 1'b0;
               p_d   = '0;
               cnt_d = '0;
               if (divisor == '0) begin
                  d_d     = dividend;
                  v_d     = '0;
                  state_d = ZDIV;
               end else begin
`ifdef DIV_SIGNED_EN
                  d_d       = magnitude(dividend);
                  v_d       = magnitude(divisor);
                  quo_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  rem_neg_d = dividend[WIDTH-1];
`else
                  d_d       = dividend;
                  v_d       = divisor;
`endif
                  busy_d  = 1'b1;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            p_d   = iter_p;
            d_d   = iter_d;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
`ifdef DIV_SIGNED_EN
               quotient_d  = apply_sign(iter_d, quo_neg_q);
               remainder_d = apply_sign(iter_p, rem_neg_q);
`else
               quotient_d  = iter_d;
               remainder_d = iter_p;
`endif
            end
         end
         ZDIV: begin
            quotient_d  = '1;
            remainder_d = d_q;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         p_q         <= '0;
         d_q         <= '0;
         v_q         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
         quo_neg_q   <= 1'b0;
         rem_neg_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         p_q         <= p_d;
         d_q         <= d_d;
         v_q         <= v_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
         quo_neg_q   <= quo_neg_d;
         rem_neg_q   <= rem_neg_d;
`endif
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_4bit.sv
// Self-checking bench for seq_divider_4bit: directed handshake cases plus random operands
// compared against an arithmetic reference model (signed when DIV_SIGNED_EN is defined).
module tb_seq_divider_4bit;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   int checks = 0;
   int errors = 0;

   seq_divider_4bit #(.WIDTH(WIDTH)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .dividend(dividend),
      .divisor(divisor),
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain arithmetic division, truncating toward zero in signed mode
   function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                                 output logic z);
      if (b == '0) begin
         q = '1;
         r = a;
         z = 1'b1;
      end else begin
         z = 1'b0;
`ifdef DIV_SIGNED_EN
         begin
            int sa;
            int sb;
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = WIDTH'(sa / sb);
            r  = WIDTH'(sa % sb);
         end
`else
         q = a / b;
         r = a % b;
`endif
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Waits (bounded) for done; returns edges waited and busy-high cycles seen
   task automatic wait_done(output int edges, output int busy_cycles);
      edges = 0;
      busy_cycles = 0;
      while (done !== 1'b1 && edges < 30) begin
         if (busy === 1'b1) busy_cycles++;
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   // Runs one operation from an IDLE cycle, checks latency, handshake and results
   task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] eq, er;
      logic             ez;
      int               k, bc;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = WIDTH'($urandom);
      divisor  = WIDTH'($urandom);
      wait_done(k, bc);
      model(a, b, eq, er, ez);
      check({tag, " latency"}, k, (b == '0) ? 1 : WIDTH);
      check({tag, " busy_cycles"}, bc, (b == '0) ? 0 : WIDTH);
      check({tag, " busy_at_done"}, busy, 1'b0);
      check({tag, " quotient"}, quotient, eq);
      check({tag, " remainder"}, remainder, er);
      check({tag, " div_by_zero"}, div_by_zero, ez);
      @(posedge clk);
      #1;
      check({tag, " done_pulse_width"}, done, 1'b0);
   endtask

   initial begin : stimulus
      int k, bc;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset quotient", quotient, '0);
      check("reset remainder", remainder, '0);
      check("reset div_by_zero", div_by_zero, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_op("13/3", 4'd13, 4'd3);
      check("13/3 spec quotient", quotient, 4'd4);
      check("13/3 spec remainder", remainder, 4'd1);
      run_op("15/1", 4'd15, 4'd1);
      run_op("3/7", 4'd3, 4'd7);
      run_op("5/0", 4'd5, 4'd0);
      check("5/0 spec quotient", quotient, 4'b1111);
      check("5/0 spec remainder", remainder, 4'd5);
      run_op("15/15", 4'd15, 4'd15);
      run_op("0/9", 4'd0, 4'd9);

      // Start re-pulsed mid-CALC must be ignored
      start    = 1'b1;
      dividend = 4'd13;
      divisor  = 4'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      start    = 1'b1;
      dividend = 4'd9;
      divisor  = 4'd2;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(k, bc);
      check("ignore latency", k + 2, WIDTH);
      check("ignore quotient", quotient, 4'd4);
      check("ignore remainder", remainder, 4'd1);
      @(posedge clk);
      #1;

      // Asynchronous reset in the middle of CALC
      start    = 1'b1;
      dividend = 4'd13;
      divisor  = 4'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst busy", busy, 1'b0);
      check("midrst done", done, 1'b0);
      check("midrst quotient", quotient, '0);
      check("midrst remainder", remainder, '0);
      check("midrst div_by_zero", div_by_zero, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_op("9/2 after reset", 4'd9, 4'd2);
      check("9/2 spec quotient", quotient, 4'd4);

      // Start held high: next op accepted two edges after the done cycle
      start    = 1'b1;
      dividend = 4'd6;
      divisor  = 4'd2;
      @(posedge clk);
      #1;
      wait_done(k, bc);
      check("held first latency", k, WIDTH);
      check("held first quotient", quotient, 4'd3);
      k = 0;
      while (busy !== 1'b1 && k < 10) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("held reaccept edges", k, 2);
      start    = 1'b0;
      dividend = 4'd14;
      wait_done(k, bc);
      check("held second quotient", quotient, 4'd3);
      check("held second remainder", remainder, 4'd0);
      @(posedge clk);
      #1;

`ifdef DIV_SIGNED_EN
      run_op("-7/2", 4'b1001, 4'd2);
      check("-7/2 spec quotient", quotient, 4'b1101);
      check("-7/2 spec remainder", remainder, 4'b1111);
      run_op("-8/-1", 4'b1000, 4'b1111);
      check("-8/-1 spec quotient", quotient, 4'b1000);
      check("-8/-1 spec remainder", remainder, 4'b0000);
`endif

      for (int i = 0; i < 40; i++) begin
         run_op("random", WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
